slib_input_sync_filt: RTL and testbench



---
 rtl/slib_input_sync_filt.sv | 58 +++++
 tb/tb_slib_input_sync_filt.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/slib_input_sync_filt.sv
// slib_input_sync_filt: multi-channel pin synchroniser with optional glitch filter and edge pulses
module slib_input_sync_filt #(
  parameter int               WIDTH         = 1,
  parameter int               STAGES        = 2,
  parameter int               FILTER_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
);
  // in bypass the Q register doubles as the last synchroniser stage
  localparam int CHAIN = FILTER_CYCLES == 0 ? STAGES - 1 : STAGES;
  localparam int CW = FILTER_CYCLES > 0 ? $clog2(FILTER_CYCLES + 1) : 1;
  logic [WIDTH-1:0] q_next;
  if (STAGES < 2) begin : g_bad_stages
    $error("slib_input_sync_filt: STAGES must be >= 2");
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    (* ASYNC_REG = "TRUE" *) logic [CHAIN-1:0] chain;
    logic s;
    assign s = chain[CHAIN-1];
    // shift the raw pin through the synchroniser chain
    always_ff @(posedge CLK or posedge RST)
      if (RST) chain <= {CHAIN{RESET_VAL[i]}};
      else begin
        chain[0] <= D[i];
        for (int k = 1; k < CHAIN; k++) chain[k] <= chain[k-1];
      end
    if (FILTER_CYCLES == 0) begin : g_byp
      assign q_next[i] = s;
    end else begin : g_filt
      localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);
      logic [CW-1:0] cnt;
      logic hit;
      assign hit = s != Q[i] && cnt == LAST;
      assign q_next[i] = hit ? s : Q[i];
      // count consecutive cycles the synchronised level differs from Q
      always_ff @(posedge CLK or posedge RST)
        if (RST) cnt <= '0;
        else cnt <= (s == Q[i] || hit) ? '0 : cnt + 1'b1;
    end
  end
  // register the qualified level together with its edge pulses
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      Q    <= RESET_VAL;
      RISE <= '0;
      FALL <= '0;
    end else begin
      Q    <= q_next;
      RISE <= q_next & ~Q;
      FALL <= ~q_next & Q;
    end
endmodule

// File: tb/tb_slib_input_sync_filt.sv
// tb_slib_input_sync_filt: filtered and bypass instances checked against a sample-history model
module tb_slib_input_sync_filt;
  localparam logic [3:0] RVF = 4'b0101;
  localparam int F = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] D = 4'b0000;
  logic [3:0] qf, rf, ff, qb, rb, fb;

  slib_input_sync_filt #(.WIDTH(4), .STAGES(3), .FILTER_CYCLES(F), .RESET_VAL(RVF)) u_filt (
    .CLK(CLK), .RST(RST), .D(D), .Q(qf), .RISE(rf), .FALL(ff));
  slib_input_sync_filt #(.WIDTH(4), .STAGES(2), .FILTER_CYCLES(0), .RESET_VAL(4'b0000)) u_byp (
    .CLK(CLK), .RST(RST), .D(D), .Q(qb), .RISE(rb), .FALL(fb));

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] qf, rf, ff, qb, rb, fb;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] dh[$];
  int         n = 0;
  logic [3:0] mqf = RVF;
  logic [3:0] mqb = 4'b0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // D value captured at edge k (1-based since reset release); before that the chain holds rv
  function automatic logic [3:0] samp(input int k, input logic [3:0] rv);
    return k >= 1 ? dh[k-1] : rv;
  endfunction

  // Filtered: S after edge j is the D captured STAGES-1 edges earlier; Q flips only when the
  // last F synchronised samples all disagree with it. Bypass: Q is D captured 1 edge earlier.
  task automatic model_edge(input logic [3:0] d);
    logic [3:0] nf, nb, sv;
    bit         all_diff;
    exp_t       x;
    dh.push_back(d);
    n++;
    nf = mqf;
    if (n >= F)
      for (int b = 0; b < 4; b++) begin
        all_diff = 1'b1;
        for (int j = n - F; j < n; j++) begin
          sv = samp(j - 2, RVF);
          if (sv[b] == mqf[b]) all_diff = 1'b0;
        end
        if (all_diff) nf[b] = ~mqf[b];
      end
    nb = samp(n - 1, 4'b0000);
    x.qf = nf; x.rf = nf & ~mqf; x.ff = ~nf & mqf;
    x.qb = nb; x.rb = nb & ~mqb; x.fb = ~nb & mqb;
    sb.push_back(x);
    mqf = nf;
    mqb = nb;
  endtask

  task automatic step(input logic [3:0] d, input int cnt = 1);
    for (int c = 0; c < cnt; c++) begin
      D = d;
      @(posedge CLK);
      model_edge(d);
      @(negedge CLK);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_q_filt", {28'd0, qf}, {28'd0, RVF});
    chk("rst_q_byp", {28'd0, qb}, 32'd0);
    chk("rst_pulses", {16'd0, rf, ff, rb, fb}, 32'd0);
  endtask

  // assert reset mid-cycle, check outputs before any clock edge, release away from edges
  task automatic hit_reset();
    #1 RST = 1'b1;
    sb.delete();
    dh.delete();
    n = 0;
    mqf = RVF;
    mqb = 4'b0000;
    #1 check_reset_outputs();
    @(negedge CLK);
    #1 RST = 1'b0;
  endtask

  // monitor: each cycle's outputs are compared against the oldest queued expectation
  always @(negedge CLK)
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("q_filt", {28'd0, qf}, {28'd0, e.qf});
      chk("rise_filt", {28'd0, rf}, {28'd0, e.rf});
      chk("fall_filt", {28'd0, ff}, {28'd0, e.ff});
      chk("q_byp", {28'd0, qb}, {28'd0, e.qb});
      chk("rise_byp", {28'd0, rb}, {28'd0, e.rb});
      chk("fall_byp", {28'd0, fb}, {28'd0, e.fb});
      chk("rise_and_fall", {24'd0, rf & ff, rb & fb}, 32'd0);
    end

  initial begin
    logic [3:0] d, m;
    #12 check_reset_outputs();
    @(negedge CLK);
    #1 RST = 1'b0;
    step(4'b0000, 9);
    step(4'b0010, 9);
    step(4'b0110, 3);
    step(4'b0010, 8);
    step(4'b0110, 4);
    step(4'b0010, 10);
    step(4'b1010);
    step(4'b0010, 5);
    step(4'b1111, 6);
    hit_reset();
    step(4'b0000, 9);
    d = 4'b0000;
    for (int it = 0; it < 10000; it++) begin
      m = 4'b0000;
      for (int b = 0; b < 4; b++) m[b] = ($urandom_range(0, 4) == 0);
      d = d ^ m;
      if ($urandom_range(0, 1999) == 0) hit_reset();
      step(d);
    end
    @(negedge CLK);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
